// File: rtl/inpref_row_buffer.sv
// -----------------------------------------------------------------------------
// inpref_row_buffer
//
// Input-prefetch stage located directly after the PE-array mode FSM. The
// upstream memory port writes feature-map rows into two row banks, which
// alternate as write and read banks. While the FSM holds in_en high, the block
// streams one element per cycle of the current read bank into the PE array.
// The 2-bit inpref mode selector sets which elements are streamed:
//   bit1 = cutting (skip element 0), bit0 = stride 1 (1) or stride 2 (0).
// The mode is captured when a row starts, so a later change on the selector
// only affects the next row.
//
// Optional feature (compile-time macro INPREF_UNDERRUN_ERR_EN):
//   When defined, a sticky underrun_err output is added. It sets when in_en
//   is high in IDLE and the read bank is not full, and it clears only on reset.
//   When undefined, the port and its logic do not exist and underrun is silent.
//
// Parameters:
//   DW   data word width in bits
//   LEN  words per row (even, >= 4)
//
// Ports:
//   clk                   clock, rising edge
//   inpref_rst_n          asynchronous active-low reset
//   inpref_mode_selector  {cut, stride1}
//   in_en                 emission enable from the FSM
//   wr_valid / wr_data    upstream write strobe and word
//   wr_ready              current write bank can take a word
//   out_valid / out_data  registered element to the PE array
//   out_last              marks the final element of a row
//   bank_full             per-bank full flags
//   busy                  EMIT state active
//   underrun_err          (INPREF_UNDERRUN_ERR_EN only) sticky underrun flag
// -----------------------------------------------------------------------------
module inpref_row_buffer #(
  parameter int DW  = 8,
  parameter int LEN = 8
) (
  input  logic          clk,
  input  logic          inpref_rst_n,
  input  logic [1:0]    inpref_mode_selector,
  input  logic          in_en,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    bank_full,
  output logic          busy
`ifdef INPREF_UNDERRUN_ERR_EN
  ,
  output logic          underrun_err
`endif
);

  localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t        state_q, state_d;

  // Row storage: two banks of LEN words.
  logic [DW-1:0] mem [0:1][0:LEN-1];

  logic [AW-1:0] wr_ptr;
  logic          wr_sel;
  logic          rd_sel;
  logic [AW-1:0] idx;
  logic          cut_q;
  logic          stride1_q;

  logic          wr_fire;
  logic          wr_done;
  logic          start;
  logic          emit_fire;
  logic          emit_last;
  logic [AW:0]   step;
  logic [AW:0]   idx_sum;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  assign wr_ready  = !bank_full[wr_sel];
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_done   = wr_fire && (wr_ptr == AW'(LEN - 1));

  assign start     = (state_q == IDLE) && in_en && bank_full[rd_sel];
  assign emit_fire = (state_q == EMIT) && in_en;

  // The sum is one bit wider than idx. Stepping past the last legal index is
  // detected this way before wrap-around hides it, and that is the final element.
  assign step      = stride1_q ? (AW+1)'(1) : (AW+1)'(2);
  assign idx_sum   = {1'b0, idx} + step;
  assign emit_last = emit_fire && (idx_sum >= (AW+1)'(LEN));

  assign busy      = (state_q == EMIT);

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    set_mask         = 2'b00;
    clr_mask         = 2'b00;
    set_mask[wr_sel] = wr_done;
    clr_mask[rd_sel] = emit_last;
  end

  // ---------------------------------------------------------------------------
  // Emission FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = EMIT;
      EMIT:    if (emit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever the statement order.
  always_ff @(posedge clk or negedge inpref_rst_n) begin
    if (!inpref_rst_n) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Write side: pointer, bank select and full flags
  // ---------------------------------------------------------------------------
  // A completing write and a completing emission always involve different
  // banks: writes go only to a non-full bank, and emission reads only a full one.
  // The set and clear masks can therefore be merged without a priority.
  always_ff @(posedge clk or negedge inpref_rst_n) begin
    if (!inpref_rst_n) begin
      wr_ptr    <= '0;
      wr_sel    <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (wr_fire) begin
        if (wr_done) begin
          wr_ptr <= '0;
          wr_sel <= !wr_sel;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
    end
  end

  // NOTE: the row storage is not reset. Clearing bank_full on reset is enough
  // to discard its contents, because data is never read from a bank whose flag
  // is clear.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_sel][wr_ptr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Read side: mode capture, index, bank select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge inpref_rst_n) begin
    if (!inpref_rst_n) begin
      idx       <= '0;
      rd_sel    <= 1'b0;
      cut_q     <= 1'b0;
      stride1_q <= 1'b1;
    end else begin
      if (start) begin
        cut_q     <= inpref_mode_selector[1];
        stride1_q <= inpref_mode_selector[0];
        idx       <= inpref_mode_selector[1] ? AW'(1) : AW'(0);
      end else if (emit_fire) begin
        idx <= idx_sum[AW-1:0];
        if (emit_last) rd_sel <= !rd_sel;
      end
    end
  end

  // Registered output stage. out_valid and out_last are low in any cycle
  // without an emission. out_data keeps the last element it emitted.
  always_ff @(posedge clk or negedge inpref_rst_n) begin
    if (!inpref_rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= emit_fire;
      out_last  <= emit_last;
      if (emit_fire) out_data <= mem[rd_sel][idx];
    end
  end

  // The start index depends on cut_q only through the value loaded at start.
  // cut_q is still kept registered so the active mode is visible for debug.
  logic unused_cut;
  assign unused_cut = cut_q;

`ifdef INPREF_UNDERRUN_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky underrun flag: the FSM requests data while no row is ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge inpref_rst_n) begin
    if (!inpref_rst_n) begin
      underrun_err <= 1'b0;
    end else if ((state_q == IDLE) && in_en && !bank_full[rd_sel]) begin
      underrun_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inpref_row_buffer.sv
// -----------------------------------------------------------------------------
// tb_inpref_row_buffer
//
// Self-checking bench for inpref_row_buffer. A behavioural model holds
// complete rows in a queue and the pending elements of the current row in a
// list built from the mode at row start. Each cycle's DUT outputs are compared
// against that model.
// -----------------------------------------------------------------------------
module tb_inpref_row_buffer;

  localparam int DW  = 8;
  localparam int LEN = 8;

  typedef logic [DW-1:0] row_t [LEN];

  logic          clk = 1'b0;
  logic          inpref_rst_n;
  logic [1:0]    inpref_mode_selector;
  logic          in_en;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    bank_full;
  logic          busy;
`ifdef INPREF_UNDERRUN_ERR_EN
  logic          underrun_err;
`endif

  inpref_row_buffer #(.DW(DW), .LEN(LEN)) dut (
    .clk                  (clk),
    .inpref_rst_n         (inpref_rst_n),
    .inpref_mode_selector (inpref_mode_selector),
    .in_en                (in_en),
    .wr_valid             (wr_valid),
    .wr_data              (wr_data),
    .wr_ready             (wr_ready),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_last             (out_last),
    .bank_full            (bank_full),
    .busy                 (busy)
`ifdef INPREF_UNDERRUN_ERR_EN
    ,
    .underrun_err         (underrun_err)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- model ----
  logic [DW-1:0] wq[$];     // words waiting to be offered upstream
  row_t          rows[$];   // complete rows not yet fully emitted
  row_t          part;      // row currently being written
  int            part_n;
  int            done_rows; // rows fully emitted since reset
  logic [DW-1:0] elist[$];  // remaining elements of the active row
  bit            active;
  bit            under;
  int            n_valid;   // emitted elements observed (for directed steps)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rows.delete();
    elist.delete();
    wq.delete();
    part_n    = 0;
    done_rows = 0;
    active    = 0;
    under     = 0;
  endtask

  function automatic logic [1:0] exp_bank_full();
    logic [1:0] bf = 2'b00;
    for (int i = 0; i < rows.size(); i++) bf[(done_rows + i) % 2] = 1'b1;
    return bf;
  endfunction

  task automatic check_outputs_idle_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_busy",      busy,      0);
    check("rst_wr_ready",  wr_ready,  1);
    check("rst_bank_full", bank_full, 0);
`ifdef INPREF_UNDERRUN_ERR_EN
    check("rst_underrun",  underrun_err, 0);
`endif
  endtask

  // One clock cycle: drive, check the combinational ready, step the model,
  // then check the registered outputs.
  task automatic run_cycle(input bit en, input bit wgate, input logic [1:0] mode);
    bit            exp_ready, acc, ev, el;
    logic [DW-1:0] ed;
    @(negedge clk);
    in_en                = en;
    inpref_mode_selector = mode;
    wr_valid             = wgate && (wq.size() > 0);
    wr_data              = (wq.size() > 0) ? wq[0] : '0;
    #1;
    exp_ready = (rows.size() < 2);
    acc       = wr_valid && exp_ready;
    check("wr_ready", wr_ready, exp_ready);
    @(posedge clk);
    #1;
    ev = 0; el = 0; ed = '0;
    if (active) begin
      if (en) begin
        ed = elist.pop_front();
        ev = 1;
        if (elist.size() == 0) begin
          el     = 1;
          active = 0;
          rows.delete(0);
          done_rows++;
        end
      end
    end else if (en) begin
      if (rows.size() > 0) begin
        active = 1;
        for (int i = (mode[1] ? 1 : 0); i < LEN; i += (mode[0] ? 1 : 2))
          elist.push_back(rows[0][i]);
      end else begin
        under = 1;
      end
    end
    if (acc) begin
      part[part_n] = wq.pop_front();
      part_n++;
      if (part_n == LEN) begin
        rows.push_back(part);
        part_n = 0;
      end
    end
    if (ev) n_valid++;
    check("out_valid", out_valid, ev);
    check("out_last",  out_last,  el);
    if (ev) check("out_data", out_data, ed);
    check("busy",      busy,      active);
    check("bank_full", bank_full, exp_bank_full());
`ifdef INPREF_UNDERRUN_ERR_EN
    check("underrun_err", underrun_err, under);
`endif
  endtask

  task automatic push_row(input int base);
    for (int i = 0; i < LEN; i++) wq.push_back(DW'(base + i));
  endtask

  // Write pending words, then emit with in_en held until the model drains.
  task automatic write_and_emit(input int base, input logic [1:0] mode);
    push_row(base);
    for (int c = 0; c < 40 && wq.size() > 0; c++) run_cycle(0, 1, mode);
    for (int c = 0; c < 40 && (active || rows.size() > 0); c++) run_cycle(1, 1, mode);
    check("drain_busy",      busy,      0);
    check("drain_bank_full", bank_full, 0);
  endtask

  // ------------------------------------------------------------- stimulus ----
  initial begin
    inpref_rst_n         = 1'b0;
    inpref_mode_selector = 2'b00;
    in_en                = 1'b0;
    wr_valid             = 1'b0;
    wr_data              = '0;
    model_reset();
    n_valid = 0;
    #12;
    check_outputs_idle_reset();
    @(negedge clk);
    inpref_rst_n = 1'b1;

    // One row in each of the four modes.
    write_and_emit(1, 2'b01);
    write_and_emit(1, 2'b00);
    write_and_emit(1, 2'b10);
    write_and_emit(1, 2'b11);

    // Two rows fill both banks. The third row stalls until row 1 is emitted.
    push_row(1);
    push_row(11);
    push_row(21);
    for (int c = 0; c < 20; c++) run_cycle(0, 1, 2'b01);
    check("both_full", bank_full, 2'b11);
    check("stall_ready", wr_ready, 0);
    for (int c = 0; c < 100 && (active || rows.size() > 0 || wq.size() > 0); c++)
      run_cycle(1, 1, 2'b01);
    check("b2b_drain", bank_full, 0);

    // Paused emission. The mode changes mid-row, which must have no effect.
    push_row(31);
    for (int c = 0; c < 20 && wq.size() > 0; c++) run_cycle(0, 1, 2'b01);
    n_valid = 0;
    for (int c = 0; c < 40 && (active || rows.size() > 0); c++)
      run_cycle((c % 2) == 0, 0, (c < 6) ? 2'b01 : 2'b00);
    check("pause_count", n_valid, LEN);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if (wq.size() < 4) wq.push_back(DW'($urandom));
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom));
    end
    wq.delete();
    for (int c = 0; c < 100 && (active || rows.size() > 0); c++) run_cycle(1, 0, 2'b01);
    check("rand_drain", busy, 0);

    // Reset after the third emitted element.
    model_reset();
    inpref_rst_n = 1'b0;
    #1;
    inpref_rst_n = 1'b1;
    push_row(41);
    push_row(51);
    for (int c = 0; c < 40 && wq.size() > 0; c++) run_cycle(0, 1, 2'b01);
    n_valid = 0;
    for (int c = 0; c < 20 && n_valid < 3; c++) run_cycle(1, 0, 2'b01);
    check("pre_reset_count", n_valid, 3);
    #2;
    inpref_rst_n = 1'b0;
    #1;
    check_outputs_idle_reset();
    model_reset();
    @(negedge clk);
    inpref_rst_n = 1'b1;
    write_and_emit(61, 2'b01);

    // Underrun: the FSM requests data while no row is buffered.
    for (int c = 0; c < 3; c++) run_cycle(1, 0, 2'b01);
    write_and_emit(71, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inpref_row_buffer.md
Name: inpref_row_buffer

Overview:
- Input-prefetch stage that sits directly downstream of the PE-array mode FSM.
- Double-buffers feature-map rows written by the upstream memory port.
- Streams one element per cycle into the PE array while the FSM drives in_en.
- Element selection is chosen by the FSM's 2-bit inpref mode selector: stride 1 or 2, with or without edge cutting.

Parameters:
- DW, 8: data word width in bits.
- LEN, 8: words per row. Must be even and at least 4.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- inpref_rst_n  in  1  asynchronous active-low reset.
- inpref_mode_selector  in  2  bit1 = cutting (drop first element); bit0 = stride 1 when 1, stride 2 when 0.
- in_en  in  1  emission enable from the FSM.
- wr_valid  in  1  upstream write strobe.
- wr_data  in  DW  upstream row word.
- wr_ready  out  1  write bank can accept a word.
- out_valid  out  1  out_data is valid this cycle.
- out_data  out  DW  element to the PE array.
- out_last  out  1  qualifies the final element of a row.
- bank_full  out  2  per-bank full flags.
- busy  out  1  EMIT state active.

Behaviour:
- Reset (async, inpref_rst_n low):
  - Clears bank_full, write pointer, write bank select (0), read bank select (0), emit index and FSM (IDLE).
  - out_valid=0, out_data=0, out_last=0, busy=0, wr_ready=1.
  - Reset mid-row or mid-emission discards all stored data immediately.
- Write side:
  - A word is accepted when wr_valid and wr_ready are both high. It is stored at wr_ptr of the write bank, and wr_ptr increments.
  - On the LEN-th accepted word: that bank's bank_full is set, wr_ptr wraps to 0, and write bank select toggles.
  - wr_ready = !bank_full[write bank].
- Emission FSM: states IDLE, EMIT.
  - IDLE -> EMIT when in_en=1 and bank_full[read bank]=1. On this transition, inpref_mode_selector is latched. Start index = 1 if cutting, else 0. Step = 1 if bit0=1, else 2.
  - In EMIT, each cycle with in_en=1 registers out_data = bank[read][idx], sets out_valid=1, and advances idx by step.
  - Cycles with in_en=0 in EMIT: out_valid=0, idx held (pause). Pauses are unlimited.
  - Element counts:
    - stride1 / no-cut: LEN elements.
    - stride1 / cut: LEN-1 elements (indices 1..LEN-1).
    - stride2 / no-cut: LEN/2 elements (0,2,...,LEN-2).
    - stride2 / cut: LEN/2 elements (1,3,...,LEN-1).
  - Final element: out_last=1 in the same cycle as its out_valid. bank_full[read bank] is cleared, read bank select toggles, and the FSM returns to IDLE.
- Latency and output registration:
  - First out_valid appears one cycle after in_en is sampled high in IDLE with a full read bank.
  - Back-to-back rows leave one idle cycle (IDLE re-entry) between rows.
  - out_valid and out_last are registered; both are 0 in any cycle without an emission.
- Mode changes: a change on inpref_mode_selector during EMIT is ignored until the next IDLE->EMIT transition.
- Simultaneous events:
  - A write completing bank A in the same cycle that emission frees bank B updates both flags independently. No word is lost.
  - When a bank's full flag is cleared, a write to that bank is accepted starting the next cycle.
- Underrun: in_en=1 in IDLE with the read bank not full produces no output; the FSM stays in IDLE.

Optional Feature:
- Macro: INPREF_UNDERRUN_ERR_EN.
- Defined:
  - Adds output port underrun_err (1 bit, reset 0).
  - underrun_err sets sticky when in_en=1 in IDLE while bank_full[read bank]=0.
  - It clears only on reset.
- Undefined: the port and its logic are absent. Underrun stays silent as described above.

Test Plan:
- Write words 1..8 into bank 0, then mode 2'b01, in_en=1 continuous -> out_data 1,2,3,4,5,6,7,8 on 8 consecutive cycles starting 1 cycle after in_en; out_last with 8; bank_full goes 01->00.
- Same row, mode 2'b00 -> out 1,3,5,7, last with 7. Mode 2'b10 -> 2,4,6,8. Mode 2'b11 -> 2..8 (7 elements).
- Write rows 1..8 and 11..18 back-to-back -> wr_ready drops after 16 words (bank_full=11). Writes of 21..28 stall until row 1 emission ends, then resume and land in bank 0.
- Mode 2'b01 with in_en toggled 1,0,1,0... -> outputs 1..8 only in in_en-high cycles, no skipped or repeated elements; change mode to 2'b00 mid-row -> still stride 1.
- Assert inpref_rst_n low after the 3rd emitted element -> all outputs 0 at once, bank_full=00, wr_ready=1; a new row after reset emits from its element 0.
- With INPREF_UNDERRUN_ERR_EN: in_en=1 with no full bank -> underrun_err=1 and stays 1 after a subsequent normal row. Without the macro: no output and no error port.
